// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared widths, dump FSM encoding and byte helper for the register dump engine
package cpu_defs;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [7:0] DUMP_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_SEND = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5
    } dump_state_t;

    // Byte lane sel of a data word, lane 0 being the least significant byte.
    function automatic logic [7:0] word_byte(input logic [DATA_W-1:0] w, input logic [1:0] sel);
        return w[8*sel +: 8];
    endfunction

endpackage

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - holds one register word, presents it a byte at a time and keeps the running XOR
module word_serializer
    import cpu_defs::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] word_in,
    input  logic              advance,
    output logic [7:0]        byte_out,
    output logic              last_byte,
    output logic [7:0]        checksum
);

    logic [DATA_W-1:0] word_q;
    logic [1:0]        cnt_q;
    logic [1:0]        lane;

    // Big-endian walks lanes 3..0, little-endian walks 0..3.
    always_comb begin
        lane      = BIG_ENDIAN ? (2'd3 - cnt_q) : cnt_q;
        byte_out  = word_byte(word_q, lane);
        last_byte = (cnt_q == 2'd3);
    end

    // Word capture, byte counter and running XOR of every data byte handed off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q   <= '0;
            cnt_q    <= 2'd0;
            checksum <= 8'h00;
        end else begin
            if (load) begin
                word_q <= word_in;
                cnt_q  <= 2'd0;
            end else if (advance) begin
                cnt_q <= cnt_q + 2'd1;
            end
            if (clear) begin
                checksum <= 8'h00;
            end else if (advance) begin
                checksum <= checksum ^ byte_out;
            end
        end
    end

endmodule

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - freezes the core and streams a framed dump of the register file to the UART
module regfile_dump
    import cpu_defs::*;
#(
    parameter int         FIRST_REG  = 1,
    parameter int         LAST_REG   = 31,
    parameter bit         BIG_ENDIAN = 1'b1,
    parameter logic [7:0] HEADER     = DUMP_HEADER
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_stall,
    output logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]     rd_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(LAST_REG);

    dump_state_t           state;
    logic [REG_ADDR_W-1:0] idx;
    logic                  xfer;
    logic                  ser_clear;
    logic                  ser_load;
    logic                  ser_advance;
    logic [7:0]            ser_byte;
    logic                  ser_last;
    logic [7:0]            ser_csum;

    // Handshake and serializer controls are all derived from registered state.
    always_comb begin
        xfer        = tx_valid && tx_ready;
        ser_clear   = (state == ST_IDLE) && start;
        ser_load    = (state == ST_LOAD);
        ser_advance = (state == ST_SEND) && xfer;
    end

    word_serializer #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .clear     (ser_clear),
        .load      (ser_load),
        .word_in   (rd_data),
        .advance   (ser_advance),
        .byte_out  (ser_byte),
        .last_byte (ser_last),
        .checksum  (ser_csum)
    );

    // Byte on the stream is selected by state from registers only, so it holds while stalled.
    always_comb begin
        tx_data = 8'h00;
        case (state)
            ST_HDR:  tx_data = HEADER;
            ST_SEND: tx_data = ser_byte;
            ST_CSUM: tx_data = ser_csum;
            default: tx_data = 8'h00;
        endcase
    end

    assign cpu_stall = busy;

    // Dump sequencer: header, then LOAD/SEND per register, then checksum; outputs registered alongside state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            idx      <= FIRST_IDX;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_valid <= 1'b0;
            rd_addr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= ST_HDR;
                        idx      <= FIRST_IDX;
                        busy     <= 1'b1;
                        tx_valid <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        state    <= ST_LOAD;
                        tx_valid <= 1'b0;
                        rd_addr  <= idx;
                    end
                end
                ST_LOAD: begin
                    state    <= ST_SEND;
                    tx_valid <= 1'b1;
                end
                ST_SEND: begin
                    if (xfer && ser_last) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_CSUM;
                        end else begin
                            state    <= ST_LOAD;
                            tx_valid <= 1'b0;
                            idx      <= idx + 1'b1;
                            rd_addr  <= idx + 1'b1;
                        end
                    end
                end
                ST_CSUM: begin
                    if (xfer) begin
                        state    <= ST_DONE;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    done    <= 1'b0;
                    rd_addr <= '0;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    tx_valid <= 1'b0;
                    rd_addr  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - scoreboard bench for regfile_dump framing, endianness, backpressure and reset
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start;
    logic        tx_ready;
    logic [31:0] regs [0:31];

    logic        busy_w     [3];
    logic        done_w     [3];
    logic        stall_w    [3];
    logic [4:0]  rd_addr_w  [3];
    logic [31:0] rd_data_w  [3];
    logic [7:0]  tx_data_w  [3];
    logic        tx_valid_w [3];

    int          sel;
    logic        s_valid, s_busy, s_done, s_stall;
    logic [7:0]  s_data;
    logic [4:0]  s_addr;

    int          pass_cnt = 0;
    int          total_cnt = 0;

    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    int          busy_cycles, done_cycles, done_at, stable_err;
    logic        ab_valid, ab_busy, ab_stall;
    logic [4:0]  ab_addr;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_rd
        assign rd_data_w[g] = (rd_addr_w[g] == 5'd0) ? 32'h0 : regs[rd_addr_w[g]];
    end

    always_comb begin
        s_valid = tx_valid_w[sel];
        s_busy  = busy_w[sel];
        s_done  = done_w[sel];
        s_stall = stall_w[sel];
        s_data  = tx_data_w[sel];
        s_addr  = rd_addr_w[sel];
    end

    regfile_dump #(.FIRST_REG(1), .LAST_REG(31), .BIG_ENDIAN(1'b1), .HEADER(8'hA5)) dut_be (
        .clk(clk), .reset(reset), .start(start[0]), .busy(busy_w[0]), .done(done_w[0]),
        .cpu_stall(stall_w[0]), .rd_addr(rd_addr_w[0]), .rd_data(rd_data_w[0]),
        .tx_data(tx_data_w[0]), .tx_valid(tx_valid_w[0]), .tx_ready(tx_ready));

    regfile_dump #(.FIRST_REG(1), .LAST_REG(31), .BIG_ENDIAN(1'b0), .HEADER(8'hA5)) dut_le (
        .clk(clk), .reset(reset), .start(start[1]), .busy(busy_w[1]), .done(done_w[1]),
        .cpu_stall(stall_w[1]), .rd_addr(rd_addr_w[1]), .rd_data(rd_data_w[1]),
        .tx_data(tx_data_w[1]), .tx_valid(tx_valid_w[1]), .tx_ready(tx_ready));

    regfile_dump #(.FIRST_REG(5), .LAST_REG(5), .BIG_ENDIAN(1'b1), .HEADER(8'hA5)) dut_one (
        .clk(clk), .reset(reset), .start(start[2]), .busy(busy_w[2]), .done(done_w[2]),
        .cpu_stall(stall_w[2]), .rd_addr(rd_addr_w[2]), .rd_data(rd_data_w[2]),
        .tx_data(tx_data_w[2]), .tx_valid(tx_valid_w[2]), .tx_ready(tx_ready));

    function automatic void clear_regs();
        for (int r = 0; r < 32; r++) regs[r] = 32'h0;
    endfunction

    // Reference frame: header, each word in the chosen byte order, XOR of the data bytes.
    function automatic void build_expected(input int first, input int last, input bit big);
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [31:0] w;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        cs = 8'h00;
        for (int r = first; r <= last; r++) begin
            w = regs[r];
            for (int k = 0; k < 4; k++) begin
                b = big ? w[8*(3-k) +: 8] : w[8*k +: 8];
                exp_q.push_back(b);
                cs = cs ^ b;
            end
        end
        exp_q.push_back(cs);
    endfunction

    // Pulses start on the selected DUT and records bytes/handshake statistics; cycle n is the n-th after the start edge.
    task automatic run_dump(input int mode, input int limit, input int restart1, input int restart2, input int abort_at);
        logic       prev_v, prev_x;
        logic [7:0] prev_d;
        got_q.delete();
        busy_cycles = 0; done_cycles = 0; done_at = -1; stable_err = 0;
        prev_v = 1'b0; prev_x = 1'b0; prev_d = 8'h00;
        @(negedge clk);
        start[sel] = 1'b1;
        @(posedge clk);
        #1;
        start = 3'b000;
        for (int n = 1; n <= limit; n++) begin
            tx_ready = (mode == 0) ? 1'b1 : ((n % 4) == 0);
            start[sel] = (n == restart1) || (n == restart2);
            @(negedge clk);
            if (s_busy) busy_cycles++;
            if (s_done) begin
                done_cycles++;
                if (done_at < 0) done_at = n;
            end
            if (prev_v && !prev_x && !(s_valid && s_data == prev_d)) stable_err++;
            if (s_valid && tx_ready) got_q.push_back(s_data);
            prev_v = s_valid; prev_x = s_valid && tx_ready; prev_d = s_data;
            if (n == abort_at) begin
                ab_addr = s_addr;
                reset = 1'b0;
                #1;
                ab_valid = s_valid; ab_busy = s_busy; ab_stall = s_stall;
                break;
            end
            if (done_at >= 0 && n >= done_at + 10) break;
            @(posedge clk);
            #1;
        end
        start = 3'b000;
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 3'b000; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({busy_w[i], done_w[i], stall_w[i], tx_valid_w[i], tx_data_w[i], rd_addr_w[i]} !== 17'h0)
                $display("FAIL reset_outputs dut%0d got busy=%b done=%b stall=%b valid=%b data=%h addr=%0d expected all zero",
                         i, busy_w[i], done_w[i], stall_w[i], tx_valid_w[i], tx_data_w[i], rd_addr_w[i]);
            else pass_cnt++;
        end
        start = 3'b111;
        @(posedge clk);
        @(negedge clk);
        start = 3'b000;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (busy_w[i] !== 1'b0 || tx_valid_w[i] !== 1'b0)
                $display("FAIL reset_wins dut%0d got busy=%b valid=%b expected 0 0", i, busy_w[i], tx_valid_w[i]);
            else pass_cnt++;
        end
    endtask

    task automatic check_frame(input string name);
        logic [7:0] e;
        total_cnt++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL %s_len got %0d expected %0d", name, got_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (got_q[i] !== e) $display("FAIL %s_byte%0d got %h expected %h", name, i, got_q[i], e);
            else pass_cnt++;
        end
    endtask

    task automatic test_big_endian();
        logic [7:0] lit [5] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};
        sel = 0; clear_regs(); regs[1] = 32'h11223344;
        build_expected(1, 31, 1'b1);
        run_dump(0, 400, -1, -1, -1);
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (got_q.size() <= i || got_q[i] !== lit[i])
                $display("FAIL be_lead%0d got %h expected %h", i, (got_q.size() > i) ? got_q[i] : 8'hxx, lit[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (got_q.size() != 126 || got_q[125] !== 8'h44)
            $display("FAIL be_checksum got %h expected 44", (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'hxx);
        else pass_cnt++;
        total_cnt++;
        if (busy_cycles !== 157) $display("FAIL be_busy_cycles got %0d expected 157", busy_cycles);
        else pass_cnt++;
        total_cnt++;
        if (done_at !== 158 || done_cycles !== 1)
            $display("FAIL be_done got cycle %0d count %0d expected cycle 158 count 1", done_at, done_cycles);
        else pass_cnt++;
        check_frame("be");
    endtask

    task automatic test_little_endian();
        logic [7:0] lit [5] = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11};
        sel = 1; clear_regs(); regs[1] = 32'h11223344;
        build_expected(1, 31, 1'b0);
        run_dump(0, 400, -1, -1, -1);
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (got_q.size() <= i || got_q[i] !== lit[i])
                $display("FAIL le_lead%0d got %h expected %h", i, (got_q.size() > i) ? got_q[i] : 8'hxx, lit[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (got_q.size() != 126 || got_q[125] !== 8'h44)
            $display("FAIL le_checksum got %h expected 44", (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'hxx);
        else pass_cnt++;
        check_frame("le");
    endtask

    task automatic test_backpressure();
        logic [7:0] lit [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        sel = 0; clear_regs(); regs[1] = 32'h11223344; regs[31] = 32'hDEADBEEF;
        build_expected(1, 31, 1'b1);
        run_dump(1, 2000, -1, -1, -1);
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (got_q.size() != 126 || got_q[121+i] !== lit[i])
                $display("FAIL bp_r31_byte%0d got %h expected %h", i, (got_q.size() == 126) ? got_q[121+i] : 8'hxx, lit[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (got_q.size() != 126 || got_q[125] !== 8'h66)
            $display("FAIL bp_checksum got %h expected 66", (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'hxx);
        else pass_cnt++;
        total_cnt++;
        if (stable_err !== 0) $display("FAIL bp_stable got %0d unstable stalls expected 0", stable_err);
        else pass_cnt++;
        total_cnt++;
        if (done_cycles !== 1) $display("FAIL bp_done got %0d pulses expected 1", done_cycles);
        else pass_cnt++;
        check_frame("bp");
    endtask

    task automatic test_restart_ignored();
        sel = 0; clear_regs(); regs[1] = 32'h11223344;
        build_expected(1, 31, 1'b1);
        run_dump(0, 400, 50, 158, -1);
        total_cnt++;
        if (done_cycles !== 1 || busy_cycles !== 157)
            $display("FAIL restart_single got done %0d busy %0d expected 1 and 157", done_cycles, busy_cycles);
        else pass_cnt++;
        check_frame("restart");
    endtask

    task automatic test_reset_mid_frame();
        sel = 0; clear_regs();
        for (int r = 1; r < 32; r++) regs[r] = $urandom;
        run_dump(0, 400, -1, -1, 49);
        total_cnt++;
        if (ab_addr !== 5'd10) $display("FAIL abort_addr got %0d expected 10", ab_addr);
        else pass_cnt++;
        total_cnt++;
        if (got_q.size() !== 39) $display("FAIL abort_partial got %0d bytes expected 39", got_q.size());
        else pass_cnt++;
        total_cnt++;
        if ({ab_valid, ab_busy, ab_stall} !== 3'b000)
            $display("FAIL abort_async got valid=%b busy=%b stall=%b expected 000", ab_valid, ab_busy, ab_stall);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        build_expected(1, 31, 1'b1);
        run_dump(0, 400, -1, -1, -1);
        check_frame("after_reset");
    endtask

    task automatic test_single_reg();
        logic [7:0] lit [6] = '{8'hA5, 8'h00, 8'h00, 8'hFF, 8'h01, 8'hFE};
        sel = 2; clear_regs(); regs[5] = 32'h0000FF01; regs[4] = 32'hFFFFFFFF; regs[6] = 32'hFFFFFFFF;
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(lit[i]);
        run_dump(0, 100, -1, -1, -1);
        total_cnt++;
        if (done_at !== 8 || busy_cycles !== 7)
            $display("FAIL single_timing got done cycle %0d busy %0d expected 8 and 7", done_at, busy_cycles);
        else pass_cnt++;
        check_frame("single");
    endtask

    initial begin
        sel = 0;
        clear_regs();
        test_reset();
        test_big_endian();
        test_little_endian();
        test_backpressure();
        test_restart_ignored();
        test_reset_mid_frame();
        test_single_reg();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
